serial_shift_out: RTL and testbench
===================================

# serial_shift_out

Parallel-to-serial transmitter for the FFT sample path: accepts one NUM_BITS-wide word through a valid/ready handshake and shifts it out one bit per `shift_strobe` tick. It is the transmit-side counterpart of the team's scalable serial-to-parallel shift register. It drives a line that idles high, resets to all-ones and supports MSB-first or LSB-first order.

## Interface
- NUM_BITS, 8, word width; at least 2.
- SHIFT_MSB, 1, bit order: 1 = MSB first, 0 = LSB first.
- clk  in  1  clock.
- n_rst  in  1  reset, asynchronous, active-low.
- load_valid  in  1  `load_data` is valid.
- load_ready  out  1  block can accept a word; high only in IDLE.
- load_data  in  NUM_BITS  word to transmit; sampled on accept only.
- shift_strobe  in  1  single-cycle bit-rate tick from an external baud/enable generator.
- serial_out  out  1  serial line; idles at 1.
- frame_active  out  1  high while a frame is on the line (SHIFT or PARITY).
- frame_done  out  1  one-cycle pulse when a frame completes.

## Operation
- Reset values:
  - state = IDLE.
  - shift register = all 1s.
  - bit_cnt = 0.
  - `serial_out` = 1, `load_ready` = 1, `frame_active` = 0, `frame_done` = 0.
- Accept occurs when `load_valid && load_ready` at a rising edge.
  - On accept: shift register ← `load_data`, bit_cnt ← 0, state ← SHIFT.
  - With SHIFT_OUT_PARITY_EN: parity_reg ← ^`load_data`.
- `serial_out` is taken directly from a register bit: sr[NUM_BITS-1] when SHIFT_MSB=1, sr[0] otherwise. No combinational path from inputs to `serial_out`.
- In SHIFT, each `shift_strobe`:
  - MSB first: shift left, fill LSB with 1.
  - LSB first: shift right, fill MSB with 1.
  - bit_cnt increments.
- A strobe arriving while bit_cnt == NUM_BITS-1 ends the data phase.
  - State ← PARITY if SHIFT_OUT_PARITY_EN is defined, otherwise IDLE.
- In PARITY, `serial_out` = parity_reg. The next strobe moves the state to IDLE and `serial_out` returns to 1.
- `frame_done` is asserted in the first IDLE cycle after a frame.
- Strobe ignored in IDLE. Strobe coincident with the accept edge is ignored; the first bit is held until the next strobe.
- `load_valid` while busy is not accepted; the word is held by the sender until `load_ready`.
- `load_ready` rises in the same cycle as `frame_done`. Back-to-back frames are therefore separated by at least one idle-high clock cycle.
- Reset mid-frame aborts immediately: line goes high and no `frame_done` is asserted.
- bit_cnt width is $clog2(NUM_BITS+1) and never wraps past NUM_BITS-1.

## Timing
- Accept at edge T:
  - First data bit on `serial_out` and `frame_active` = 1 from T+1.
  - `load_ready` = 0 from T+1.
- Each bit is held from the edge that presents it until the edge after the next strobe.
- Frame length is NUM_BITS strobes, or NUM_BITS+1 with parity.
- Given the final strobe at edge S:
  - At S+1: `serial_out` = 1, `frame_active` = 0, `frame_done` = 1, `load_ready` = 1.
  - At S+2: `frame_done` = 0.
- Minimum frame is NUM_BITS strobes and NUM_BITS+1 clock cycles (strobe tied high).

## Configuration
- SHIFT_OUT_PARITY_EN
  - Defined: PARITY state exists, and one even-parity bit (XOR of the data bits) follows the data bits.
  - Undefined: the PARITY state, parity_reg and the parity logic are not compiled, and the frame is exactly NUM_BITS bits.

## Structure
- Package `serial_shift_out_pkg` holds:
  - `typedef enum logic [1:0] {IDLE, SHIFT, PARITY} sso_state_t`.
  - Localparam `SSO_IDLE_LEVEL = 1'b1`.
- Sub-module `sso_bit_counter` is the natural split: clear/enable/rollover-flag counter, parameterised width, asserting its flag at count NUM_BITS-1.
- Top module holds the FSM, the shift register and the parity register.

## Test plan
- Reset, no stimulus:
  - `serial_out`=1, `load_ready`=1, `frame_active`=0 for 20 cycles.
  - Strobes toggling meanwhile must not change the line.
- NUM_BITS=8, SHIFT_MSB=1, load 8'h1E, strobe every 4 clocks:
  - Line shows 0,0,0,1,1,1,1,0, each bit held 4 clocks.
  - `frame_done` pulses once, then the line reads 1.
- SHIFT_MSB=0, load 8'h1E: line shows 0,1,1,1,1,0,0,0.
- Parity build, load 8'h1F, MSB first:
  - Line shows 0,0,0,1,1,1,1,1 then parity 1.
  - 9 strobes per frame.
- Assert `load_valid` continuously with a new word while busy:
  - No accept until `frame_done`.
  - Second frame starts after exactly one idle-high cycle.
- Drop `n_rst` after the 3rd bit of 8'hA5:
  - Line goes 1 asynchronously, and `frame_done` never pulses.
  - After release, a fresh load of 8'h3C shifts 0,0,1,1,1,1,0,0.

Source files
------------

// File: rtl/serial_shift_out_pkg.sv
// Shared types and constants for the serial_shift_out transmitter.
// The optional parity bit is enabled by defining SHIFT_OUT_PARITY_EN.
package serial_shift_out_pkg;

   typedef enum logic [1:0] {IDLE, SHIFT, PARITY} sso_state_t;

   localparam logic SSO_IDLE_LEVEL = 1'b1;

   function automatic int sso_cnt_width(input int num_bits);
      return $clog2(num_bits + 1);
   endfunction

endpackage

// File: rtl/sso_bit_counter.sv
// Bit counter with synchronous clear and enable; flag marks the last bit and
// the count rolls back to zero on the enabled cycle where the flag is set.
module sso_bit_counter #(
   parameter int WIDTH = 4,
   parameter int LAST  = 7
) (
   input  logic clk,
   input  logic n_rst,
   input  logic clear,
   input  logic enable,
   output logic flag
);

   logic [WIDTH-1:0] bit_cnt;

   assign flag = (bit_cnt == WIDTH'(LAST));

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst)
         bit_cnt <= '0;
      else if (clear)
         bit_cnt <= '0;
      else if (enable)
         bit_cnt <= flag ? '0 : bit_cnt + 1'b1;
   end

endmodule

// File: rtl/serial_shift_out.sv
// Parallel-to-serial transmitter: one word per valid/ready accept, one bit per
// shift_strobe, line idles high. Optional parity bit via SHIFT_OUT_PARITY_EN.
module serial_shift_out
   import serial_shift_out_pkg::*;
#(
   parameter int NUM_BITS  = 8,
   parameter bit SHIFT_MSB = 1'b1
) (
   input  logic                clk,
   input  logic                n_rst,
   input  logic                load_valid,
   output logic                load_ready,
   input  logic [NUM_BITS-1:0] load_data,
   input  logic                shift_strobe,
   output logic                serial_out,
   output logic                frame_active,
   output logic                frame_done
);

   localparam int CNT_W   = sso_cnt_width(NUM_BITS);
   localparam int OUT_IDX = SHIFT_MSB ? NUM_BITS - 1 : 0;

   sso_state_t          state, next_state;
   logic [NUM_BITS-1:0] sr, sr_shift;
   logic                accept, shift_en, cnt_en, frame_end, last_bit;

`ifdef SHIFT_OUT_PARITY_EN
   logic                parity_reg;
`endif

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst)
         state <= IDLE;
      else
         state <= next_state;
   end

   always_comb begin
      next_state   = state;
      accept       = 1'b0;
      shift_en     = 1'b0;
      cnt_en       = 1'b0;
      frame_end    = 1'b0;
      load_ready   = 1'b0;
      frame_active = 1'b0;
      case (state)
         IDLE: begin
            load_ready = 1'b1;
            if (load_valid) begin
               accept     = 1'b1;
               next_state = SHIFT;
            end
         end
         SHIFT: begin
            frame_active = 1'b1;
            if (shift_strobe) begin
               shift_en = 1'b1;
               cnt_en   = 1'b1;
               if (last_bit) begin
`ifdef SHIFT_OUT_PARITY_EN
                  next_state = PARITY;
`else
                  next_state = IDLE;
                  frame_end  = 1'b1;
`endif
               end
            end
         end
`ifdef SHIFT_OUT_PARITY_EN
         PARITY: begin
            frame_active = 1'b1;
            if (shift_strobe) begin
               shift_en   = 1'b1;
               next_state = IDLE;
               frame_end  = 1'b1;
            end
         end
`endif
         default: next_state = IDLE;
      endcase
   end

   sso_bit_counter #(
      .WIDTH (CNT_W),
      .LAST  (NUM_BITS - 1)
   ) u_bit_counter (
      .clk    (clk),
      .n_rst  (n_rst),
      .clear  (accept),
      .enable (cnt_en),
      .flag   (last_bit)
   );

   // The fill bit reaches the output position exactly as the data runs out,
   // so the line returns to the idle level without any output mux.
   always_comb begin
      if (SHIFT_MSB)
         sr_shift = {sr[NUM_BITS-2:0], SSO_IDLE_LEVEL};
      else
         sr_shift = {SSO_IDLE_LEVEL, sr[NUM_BITS-1:1]};
`ifdef SHIFT_OUT_PARITY_EN
      if (state == SHIFT && last_bit)
         sr_shift[OUT_IDX] = parity_reg;
`endif
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst)
         sr <= {NUM_BITS{SSO_IDLE_LEVEL}};
      else if (accept)
         sr <= load_data;
      else if (shift_en)
         sr <= sr_shift;
   end

`ifdef SHIFT_OUT_PARITY_EN
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst)
         parity_reg <= 1'b0;
      else if (accept)
         parity_reg <= ^load_data;
   end
`endif

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst)
         frame_done <= 1'b0;
      else
         frame_done <= frame_end;
   end

   assign serial_out = sr[OUT_IDX];

endmodule

// File: tb/tb_serial_shift_out.sv
// Directed bench for serial_shift_out: MSB-first and LSB-first instances share
// stimulus; frame length follows SHIFT_OUT_PARITY_EN.
module tb_serial_shift_out;

`ifdef SHIFT_OUT_PARITY_EN
   localparam int FLEN = 9;
`else
   localparam int FLEN = 8;
`endif

   logic       clk = 1'b0;
   logic       n_rst;
   logic       load_valid;
   logic [7:0] load_data;
   logic       shift_strobe;
   logic       so_m, rdy_m, act_m, done_m;
   logic       so_l, rdy_l, act_l, done_l;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   serial_shift_out #(.NUM_BITS(8), .SHIFT_MSB(1'b1)) dut_m (
      .clk (clk), .n_rst (n_rst), .load_valid (load_valid), .load_ready (rdy_m),
      .load_data (load_data), .shift_strobe (shift_strobe), .serial_out (so_m),
      .frame_active (act_m), .frame_done (done_m)
   );

   serial_shift_out #(.NUM_BITS(8), .SHIFT_MSB(1'b0)) dut_l (
      .clk (clk), .n_rst (n_rst), .load_valid (load_valid), .load_ready (rdy_l),
      .load_data (load_data), .shift_strobe (shift_strobe), .serial_out (so_l),
      .frame_active (act_l), .frame_done (done_l)
   );

   // Sends one word; exp_m/exp_l list the expected line bits first-bit-in-[7].
   task automatic send_frame(input logic [7:0] data, input logic [7:0] exp_m,
                             input logic [7:0] exp_l, input int per, input string name);
      logic em, el;
      @(posedge clk); #1;
      load_valid = 1'b1; load_data = data; shift_strobe = 1'b0;
      @(posedge clk); #1;
      load_valid = 1'b0;
      for (int i = 0; i < FLEN; i++) begin
         em = (i < 8) ? exp_m[7-i] : ^data;
         el = (i < 8) ? exp_l[7-i] : ^data;
         for (int k = 0; k < per; k++) begin
            shift_strobe = (k == per - 1);
            @(negedge clk);
            n_cmp++;
            if ({so_m, so_l, act_m, act_l, rdy_m, done_m, done_l} !== {em, el, 5'b11000}) begin
               n_bad++;
               $display("FAIL %s bit%0d clk%0d: got so_m/so_l/act/act/rdy/done/done=%b want %b",
                        name, i, k, {so_m, so_l, act_m, act_l, rdy_m, done_m, done_l},
                        {em, el, 5'b11000});
            end
            @(posedge clk); #1;
         end
      end
      shift_strobe = 1'b0;
      @(negedge clk);
      n_cmp++;
      if ({so_m, so_l, done_m, done_l, rdy_m, act_m} !== 6'b111110) begin
         n_bad++;
         $display("FAIL %s end: got so_m/so_l/done/done/rdy/act=%b want 111110",
                  name, {so_m, so_l, done_m, done_l, rdy_m, act_m});
      end
      @(posedge clk); #1;
      @(negedge clk);
      n_cmp++;
      if ({so_m, so_l, done_m, done_l, rdy_m} !== 5'b11001) begin
         n_bad++;
         $display("FAIL %s after: got so_m/so_l/done/done/rdy=%b want 11001",
                  name, {so_m, so_l, done_m, done_l, rdy_m});
      end
   endtask

   task automatic test_reset();
      n_rst = 1'b0; load_valid = 1'b0; load_data = 8'h00; shift_strobe = 1'b0;
      @(negedge clk);
      n_cmp++;
      if ({so_m, so_l, rdy_m, act_m, done_m} !== 5'b11100) begin
         n_bad++;
         $display("FAIL reset_in: got so_m/so_l/rdy/act/done=%b want 11100",
                  {so_m, so_l, rdy_m, act_m, done_m});
      end
      n_rst = 1'b1;
      for (int c = 0; c < 20; c++) begin
         @(posedge clk); #1;
         shift_strobe = ~shift_strobe;
         @(negedge clk);
         n_cmp++;
         if ({so_m, so_l, rdy_m, rdy_l, act_m, act_l, done_m} !== 7'b1111000) begin
            n_bad++;
            $display("FAIL reset_idle c%0d: got %b want 1111000", c,
                     {so_m, so_l, rdy_m, rdy_l, act_m, act_l, done_m});
         end
      end
      @(posedge clk); #1;
      shift_strobe = 1'b0;
   endtask

   task automatic test_msb_lsb();
      // 8'h1E: MSB first 0,0,0,1,1,1,1,0 ; LSB first 0,1,1,1,1,0,0,0
      send_frame(8'h1E, 8'h1E, 8'h78, 4, "frame_1e");
   endtask

   task automatic test_parity();
      // 8'h1F: MSB first 0,0,0,1,1,1,1,1 ; LSB first 1,1,1,1,1,0,0,0 ; parity 1
      send_frame(8'h1F, 8'h1F, 8'hF8, 2, "frame_1f");
   endtask

   task automatic test_back_to_back();
      logic [7:0] a, b;
      logic       em;
      a = 8'hC3; b = 8'h5A;
      @(posedge clk); #1;
      load_valid = 1'b1; load_data = a; shift_strobe = 1'b1;
      @(posedge clk); #1;
      load_data = b;
      for (int i = 0; i < FLEN; i++) begin
         em = (i < 8) ? a[7-i] : ^a;
         @(negedge clk);
         n_cmp++;
         if ({so_m, rdy_m, act_m, done_m} !== {em, 3'b010}) begin
            n_bad++;
            $display("FAIL b2b_a bit%0d: got so/rdy/act/done=%b want %b", i,
                     {so_m, rdy_m, act_m, done_m}, {em, 3'b010});
         end
         @(posedge clk); #1;
      end
      @(negedge clk);
      n_cmp++;
      if ({so_m, rdy_m, act_m, done_m} !== 4'b1101) begin
         n_bad++;
         $display("FAIL b2b_gap: got so/rdy/act/done=%b want 1101", {so_m, rdy_m, act_m, done_m});
      end
      @(posedge clk); #1;
      load_valid = 1'b0;
      for (int i = 0; i < FLEN; i++) begin
         em = (i < 8) ? b[7-i] : ^b;
         @(negedge clk);
         n_cmp++;
         if ({so_m, rdy_m, act_m, done_m} !== {em, 3'b010}) begin
            n_bad++;
            $display("FAIL b2b_b bit%0d: got so/rdy/act/done=%b want %b", i,
                     {so_m, rdy_m, act_m, done_m}, {em, 3'b010});
         end
         @(posedge clk); #1;
      end
      shift_strobe = 1'b0;
      @(negedge clk);
      n_cmp++;
      if ({so_m, rdy_m, act_m, done_m} !== 4'b1101) begin
         n_bad++;
         $display("FAIL b2b_end: got so/rdy/act/done=%b want 1101", {so_m, rdy_m, act_m, done_m});
      end
      @(posedge clk); #1;
   endtask

   task automatic test_reset_abort();
      @(posedge clk); #1;
      load_valid = 1'b1; load_data = 8'hA5; shift_strobe = 1'b0;
      @(posedge clk); #1;
      load_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         shift_strobe = 1'b0;
         @(posedge clk); #1;
         shift_strobe = 1'b1;
         @(posedge clk); #1;
      end
      shift_strobe = 1'b0;
      // 4th bit of 8'hA5 is 0 in either order
      @(negedge clk);
      n_cmp++;
      if ({so_m, so_l, act_m} !== 3'b001) begin
         n_bad++;
         $display("FAIL abort_pre: got so_m/so_l/act=%b want 001", {so_m, so_l, act_m});
      end
      #2 n_rst = 1'b0;
      #1;
      n_cmp++;
      if ({so_m, so_l, act_m, act_l, rdy_m, done_m} !== 6'b110010) begin
         n_bad++;
         $display("FAIL abort_async: got so_m/so_l/act/act/rdy/done=%b want 110010",
                  {so_m, so_l, act_m, act_l, rdy_m, done_m});
      end
      repeat (2) @(posedge clk);
      @(negedge clk);
      n_rst = 1'b1;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         n_cmp++;
         if ({so_m, so_l, done_m, done_l, rdy_m} !== 5'b11001) begin
            n_bad++;
            $display("FAIL abort_post c%0d: got so_m/so_l/done/done/rdy=%b want 11001", c,
                     {so_m, so_l, done_m, done_l, rdy_m});
         end
      end
      // 8'h3C: 0,0,1,1,1,1,0,0 in either order
      send_frame(8'h3C, 8'h3C, 8'h3C, 2, "frame_3c");
   endtask

   initial begin
      test_reset();
      test_msb_lsb();
      test_parity();
      test_back_to_back();
      test_reset_abort();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
